mat_sub_scheduler: RTL and testbench

MAT_SUB_SCHEDULER -- requirements
Module: mat_sub_scheduler

---
 rtl/mat_sub_scheduler.sv | 156 +++++++++++++++
 tb/tb_mat_sub_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_sub_scheduler.sv
// mat_sub_scheduler: streams a SIZE_A x SIZE_B matrix of doubles through an
// external pipelined DP-FP subtractor (element - scale), one element per cycle,
// and writes each result back in row-major order LATENCY cycles later.
module mat_sub_scheduler #(
  parameter int SIZE_A  = 8,
  parameter int SIZE_B  = 8,
  parameter int LATENCY = 7,
  localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1,
  localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [63:0]   scale,
  output logic [RW-1:0] rd_row,
  output logic [CW-1:0] rd_col,
  input  logic [63:0]   rd_data,
  output logic          sub_en,
  output logic [63:0]   sub_dataa,
  output logic [63:0]   sub_datab,
  input  logic [63:0]   sub_result,
  input  logic [3:0]    sub_flags,
  output logic          wr_en,
  output logic [RW-1:0] wr_row,
  output logic [CW-1:0] wr_col,
  output logic [63:0]   wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [RW-1:0]       issue_row_reg, wr_row_reg;
  logic [CW-1:0]       issue_col_reg, wr_col_reg;
  logic [63:0]         scale_reg;
  logic [LATENCY-1:0]  vld_reg, vld_next;
  logic                err_reg;
  logic                accept, issue, issue_last, write_last;
  logic                unused_flags;

  // Underflow and zero are informational only; they never raise err.
  assign unused_flags = ^{sub_flags[2], sub_flags[0]};

  assign issue_last = (issue_row_reg == RW'(SIZE_A - 1)) && (issue_col_reg == CW'(SIZE_B - 1));
  assign write_last = (wr_row_reg == RW'(SIZE_A - 1)) && (wr_col_reg == CW'(SIZE_B - 1));

  // The oldest in-flight slot lines up with the subtractor output.
  assign wr_en = vld_reg[LATENCY-1];

  // Shift-in value for the in-flight tracker: stage 0 takes this cycle's issue.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_vld
    if (gi == 0) begin : g_head
      assign vld_next[gi] = issue;
    end else begin : g_tail
      assign vld_next[gi] = vld_reg[gi-1];
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    issue      = 1'b0;
    sub_en     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        sub_en = 1'b1;
        issue  = 1'b1;
        if (issue_last) state_next = DRAIN;
      end
      DRAIN: begin
        sub_en = 1'b1;
        if (wr_en && write_last && (vld_next == '0)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // In-flight tracker advances in lockstep with the subtractor clock enable.
  always_ff @(posedge clk) begin
    if (rst)         vld_reg <= '0;
    else if (sub_en) vld_reg <= vld_next;
  end

  // Issue/write row-major counters and the latched subtrahend.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_row_reg <= '0;
      issue_col_reg <= '0;
      wr_row_reg    <= '0;
      wr_col_reg    <= '0;
      scale_reg     <= '0;
    end else if (accept) begin
      issue_row_reg <= '0;
      issue_col_reg <= '0;
      wr_row_reg    <= '0;
      wr_col_reg    <= '0;
      scale_reg     <= scale;
    end else begin
      if (issue) begin
        if (issue_col_reg == CW'(SIZE_B - 1)) begin
          issue_col_reg <= '0;
          if (issue_row_reg != RW'(SIZE_A - 1)) issue_row_reg <= issue_row_reg + RW'(1);
        end else begin
          issue_col_reg <= issue_col_reg + CW'(1);
        end
      end
      if (wr_en) begin
        if (wr_col_reg == CW'(SIZE_B - 1)) begin
          wr_col_reg <= '0;
          if (wr_row_reg != RW'(SIZE_A - 1)) wr_row_reg <= wr_row_reg + RW'(1);
        end else begin
          wr_col_reg <= wr_col_reg + CW'(1);
        end
      end
    end
  end

  // Sticky error: overflow or NaN on any written result, cleared by a new pass.
  always_ff @(posedge clk) begin
    if (rst)                                       err_reg <= 1'b0;
    else if (accept)                               err_reg <= 1'b0;
    else if (wr_en && (sub_flags[3] | sub_flags[1])) err_reg <= 1'b1;
  end

  assign err       = err_reg;
  assign rd_row    = issue ? issue_row_reg : '0;
  assign rd_col    = issue ? issue_col_reg : '0;
  assign sub_dataa = issue ? rd_data : '0;
  assign sub_datab = scale_reg;
  assign wr_row    = wr_en ? wr_row_reg : '0;
  assign wr_col    = wr_en ? wr_col_reg : '0;
  assign wr_data   = sub_result;

endmodule

// File: tb/tb_mat_sub_scheduler.sv
// tb_mat_sub_scheduler: three scheduler instances (2x2/L7, 8x8/L7, 1x1/L1),
// each with a behavioural matrix memory and pipelined subtractor, checked
// cycle by cycle against the expected pass timeline.
module tb_mat_sub_scheduler;

  localparam int CFG_A[3] = '{2, 8, 1};
  localparam int CFG_B[3] = '{2, 8, 1};
  localparam int CFG_L[3] = '{7, 7, 1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a [3];
  logic [63:0] scale_a [3];
  logic [3:0]  flags_a [3];
  logic [63:0] mem_a   [3][64];
  logic        busy_a [3], done_a [3], err_a [3], wr_en_a [3], sub_en_a [3];
  logic [2:0]  rd_row_a [3], rd_col_a [3], wr_row_a [3], wr_col_a [3];
  logic [63:0] wr_data_a [3];

  int checks = 0;
  int errors = 0;
  int pass_no = 0;
  logic [63:0] cap [64];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int SA  = CFG_A[gi];
    localparam int SB  = CFG_B[gi];
    localparam int LAT = CFG_L[gi];
    localparam int RW  = (SA > 1) ? $clog2(SA) : 1;
    localparam int CW  = (SB > 1) ? $clog2(SB) : 1;
    logic [RW-1:0] rd_row, wr_row;
    logic [CW-1:0] rd_col, wr_col;
    logic [63:0]   rd_data, sub_dataa, sub_datab, sub_result, wr_data;
    logic          sub_en, wr_en, busy, done, err;
    logic [63:0]   pipe [LAT];

    mat_sub_scheduler #(.SIZE_A(SA), .SIZE_B(SB), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst), .start(start_a[gi]), .scale(scale_a[gi]),
      .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
      .sub_en(sub_en), .sub_dataa(sub_dataa), .sub_datab(sub_datab),
      .sub_result(sub_result), .sub_flags(flags_a[gi]),
      .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err)
    );

    always_comb rd_data = mem_a[gi][int'(rd_row) * SB + int'(rd_col)];

    always_ff @(posedge clk) begin
      if (sub_en) begin
        pipe[0] <= $realtobits($bitstoreal(sub_dataa) - $bitstoreal(sub_datab));
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign sub_result = pipe[LAT-1];

    assign busy_a[gi]    = busy;
    assign done_a[gi]    = done;
    assign err_a[gi]     = err;
    assign wr_en_a[gi]   = wr_en;
    assign sub_en_a[gi]  = sub_en;
    assign rd_row_a[gi]  = 3'(rd_row);
    assign rd_col_a[gi]  = 3'(rd_col);
    assign wr_row_a[gi]  = 3'(wr_row);
    assign wr_col_a[gi]  = 3'(wr_col);
    assign wr_data_a[gi] = wr_data;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One pass on instance inst; expectations come from the pass timeline:
  // issues in 1..N, writes in 1+L..N+L, done in N+L+1.
  task automatic run_pass(input int inst, input real scl, input int inj_idx,
                          input logic [3:0] inj_flags, input int rst_at, input bit hold,
                          input bit fixed_mem, output int done_cyc, output int nwr);
    int n, l, sb, t, idx;
    bit live, second, e_wr;
    string p;
    n = CFG_A[inst] * CFG_B[inst];
    l = CFG_L[inst];
    sb = CFG_B[inst];
    t = n + l + 3;
    if (!fixed_mem)
      for (int i = 0; i < n; i++)
        mem_a[inst][i] = $realtobits(real'($urandom_range(0, 4000)) / 8.0 - 250.0);
    done_cyc = -1;
    nwr = 0;
    pass_no++;
    @(negedge clk);
    start_a[inst] = 1'b1;
    scale_a[inst] = $realtobits(scl);
    for (int c = 1; c <= t; c++) begin
      @(negedge clk);
      start_a[inst] = hold;
      rst = (c == rst_at);
      flags_a[inst] = (c == 1 + l + inj_idx) ? inj_flags : 4'd0;
      live   = (rst_at < 0) || (c <= rst_at);
      second = hold && (c >= n + l + 3);
      e_wr   = live && (c >= 1 + l) && (c <= n + l);
      p = $sformatf("p%0d i%0d c%0d", pass_no, inst, c);
      chk({p, " busy"}, 64'(busy_a[inst]), 64'(live && ((c <= n + l + 1) || second)));
      chk({p, " done"}, 64'(done_a[inst]), 64'(live && (c == n + l + 1)));
      chk({p, " sub_en"}, 64'(sub_en_a[inst]), 64'(live && ((c <= n + l) || second)));
      chk({p, " err"}, 64'(err_a[inst]), 64'(live && !second && inj_idx >= 0 &&
                                            (inj_flags & 4'b1010) != 0 && c > 1 + l + inj_idx));
      chk({p, " rd_row"}, 64'(rd_row_a[inst]), (live && c <= n) ? 64'((c - 1) / sb) : 64'd0);
      chk({p, " rd_col"}, 64'(rd_col_a[inst]), (live && c <= n) ? 64'((c - 1) % sb) : 64'd0);
      chk({p, " wr_en"}, 64'(wr_en_a[inst]), 64'(e_wr));
      idx = c - 1 - l;
      chk({p, " wr_row"}, 64'(wr_row_a[inst]), e_wr ? 64'(idx / sb) : 64'd0);
      chk({p, " wr_col"}, 64'(wr_col_a[inst]), e_wr ? 64'(idx % sb) : 64'd0);
      if (e_wr) begin
        chk({p, " wr_data"}, wr_data_a[inst],
            $realtobits($bitstoreal(mem_a[inst][idx]) - scl));
        cap[idx] = wr_data_a[inst];
      end
      if (wr_en_a[inst]) nwr++;
      if (done_a[inst] && done_cyc < 0) done_cyc = c;
    end
    start_a[inst] = 1'b0;
    flags_a[inst] = 4'd0;
    rst = 1'b0;
    if (hold || rst_at >= 0) begin
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
    end
  endtask

  typedef struct {
    int inst; int inj_idx; logic [3:0] inj_flags; int rst_at; bit hold;
    int exp_done; int exp_nwr;
  } pass_t;

  typedef struct { logic st; logic rs; logic busy; logic done; logic wr; } cyc_t;

  pass_t ptab [11];
  cyc_t  seq [10];
  real   exp_fix [4];
  int    dc, nw, inst, n, l, ii;
  logic [3:0] fl;

  initial begin
    ptab[0]  = '{1, -1, 4'b0000, -1, 1'b0, 72, 64};
    ptab[1]  = '{0,  2, 4'b0010, -1, 1'b0, 12, 4};
    ptab[2]  = '{0, -1, 4'b0000, -1, 1'b0, 12, 4};
    ptab[3]  = '{0,  1, 4'b0100, -1, 1'b0, 12, 4};
    ptab[4]  = '{0,  0, 4'b1000, -1, 1'b0, 12, 4};
    ptab[5]  = '{0, -1, 4'b0000,  5, 1'b0, -1, 0};
    ptab[6]  = '{2, -1, 4'b0000, -1, 1'b0,  3, 1};
    ptab[7]  = '{2,  0, 4'b0010, -1, 1'b0,  3, 1};
    ptab[8]  = '{1, 10, 4'b1000, -1, 1'b1, 72, 64};
    ptab[9]  = '{1, -1, 4'b0000, 40, 1'b0, -1, 33};
    ptab[10] = '{1, -1, 4'b0000, 70, 1'b0, -1, 63};

    seq[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    seq[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    seq[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    seq[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    seq[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    seq[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    seq[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    seq[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    seq[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    seq[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    exp_fix = '{2.0, 4.0, 6.0, 8.0};

    // Reset with start held high: reset must win and leave everything idle.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b1; scale_a[i] = '0; flags_a[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset i%0d busy", i), 64'(busy_a[i]), 64'd0);
      chk($sformatf("reset i%0d done", i), 64'(done_a[i]), 64'd0);
      chk($sformatf("reset i%0d err", i), 64'(err_a[i]), 64'd0);
      chk($sformatf("reset i%0d wr_en", i), 64'(wr_en_a[i]), 64'd0);
      chk($sformatf("reset i%0d sub_en", i), 64'(sub_en_a[i]), 64'd0);
      start_a[i] = 1'b0;
    end
    rst = 1'b0;

    // 2x2 worked example: {3,5,7,9} - 1.0.
    mem_a[0][0] = $realtobits(3.0);
    mem_a[0][1] = $realtobits(5.0);
    mem_a[0][2] = $realtobits(7.0);
    mem_a[0][3] = $realtobits(9.0);
    run_pass(0, 1.0, -1, 4'd0, -1, 1'b0, 1'b1, dc, nw);
    chk("fixed done_cycle", 64'(dc), 64'd12);
    chk("fixed writes", 64'(nw), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("fixed data%0d", i), cap[i], $realtobits(exp_fix[i]));

    // Table of directed passes.
    for (int p = 0; p < 11; p++) begin
      run_pass(ptab[p].inst, real'($urandom_range(0, 800)) / 4.0 - 100.0,
               ptab[p].inj_idx, ptab[p].inj_flags, ptab[p].rst_at, ptab[p].hold,
               1'b0, dc, nw);
      chk($sformatf("tab%0d done_cycle", p), 64'(dc), 64'(ptab[p].exp_done));
      chk($sformatf("tab%0d writes", p), 64'(nw), 64'(ptab[p].exp_nwr));
    end

    // 1x1/L1 with start held, reset colliding with start, re-accept after reset.
    @(negedge clk);
    start_a[2] = 1'b1;
    scale_a[2] = $realtobits(0.5);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("seq c%0d busy", c), 64'(busy_a[2]), 64'(seq[c-1].busy));
      chk($sformatf("seq c%0d done", c), 64'(done_a[2]), 64'(seq[c-1].done));
      chk($sformatf("seq c%0d wr_en", c), 64'(wr_en_a[2]), 64'(seq[c-1].wr));
      start_a[2] = seq[c-1].st;
      rst = seq[c-1].rs;
    end
    start_a[2] = 1'b0;
    rst = 1'b0;

    // Randomized passes.
    for (int r = 0; r < 8; r++) begin
      inst = $urandom_range(0, 2);
      n = CFG_A[inst] * CFG_B[inst];
      l = CFG_L[inst];
      ii = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, n - 1));
      fl = 4'($urandom_range(0, 15));
      run_pass(inst, real'($urandom_range(0, 800)) / 4.0 - 100.0, ii, fl, -1, 1'b0,
               1'b0, dc, nw);
      chk($sformatf("rand%0d done_cycle", r), 64'(dc), 64'(n + l + 1));
      chk($sformatf("rand%0d writes", r), 64'(nw), 64'(n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
